fl_binder_rr: RTL and testbench
===============================

// Module: fl_binder_rr
// PURPOSE
//  Merges INPUT_COUNT FrameLink streams into one FrameLink stream: the opposite end of fl_splitter.
//  Frame-atomic round-robin: once an input is granted, every word of its frame passes before switching.
//  Frame parts (SOP/EOP) pass unchanged. One registered output stage (1-cycle latency).
//  Sits in front of a single consumer (DMA/HW-SW buffer) fed by several splitter/processing branches.
// PARAMETERS
//  DATA_WIDTH   64  FrameLink data width in bits (multiple of 8)
//  DREM_WIDTH    3  log2(DATA_WIDTH/8); DREM = index of the last valid byte in the word
//  INPUT_COUNT   4  number of RX FrameLink inputs, 2..16
// PORTS
//  CLK          in   1                         clock
//  RESET_N      in   1                         asynchronous reset, active low
//  RX_DATA      in   INPUT_COUNT*DATA_WIDTH    input i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//  RX_DREM      in   INPUT_COUNT*DREM_WIDTH    per-input DREM, packed the same way
//  RX_SOF_N     in   INPUT_COUNT               per-input start of frame, active low
//  RX_EOF_N     in   INPUT_COUNT               per-input end of frame, active low
//  RX_SOP_N     in   INPUT_COUNT               per-input start of part, active low
//  RX_EOP_N     in   INPUT_COUNT               per-input end of part, active low
//  RX_SRC_RDY_N in   INPUT_COUNT               per-input source ready, active low
//  RX_DST_RDY_N out  INPUT_COUNT               per-input destination ready, active low
//  TX_DATA      out  DATA_WIDTH                merged data
//  TX_DREM      out  DREM_WIDTH                merged DREM
//  TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out 1  merged framing, active low
//  TX_SRC_RDY_N out  1                         output word valid, active low
//  TX_DST_RDY_N in   1                         consumer ready, active low
// BEHAVIOUR
//  Reset (RESET_N=0, async): FSM=IDLE, RR_PTR=0, output register empty.
//   TX_SRC_RDY_N=1, TX_SOF/EOF/SOP/EOP_N=1, TX_DATA=0, TX_DREM=0, all RX_DST_RDY_N=1.
//  Transfer: RX word i moves when RX_SRC_RDY_N[i]=0 and RX_DST_RDY_N[i]=0.
//   TX word moves when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
//  Output register: accepts a word when empty or popped in the same cycle (full throughput).
//   It holds DATA, DREM and framing stable while TX_SRC_RDY_N=0 and TX_DST_RDY_N=1.
//  FSM IDLE:
//   - Scans inputs RR_PTR, RR_PTR+1, ... (mod INPUT_COUNT) and picks the first with RX_SRC_RDY_N=0.
//   - Registers it as GRANT and moves to LOCKED. No transfer happens in this cycle.
//   - All RX_DST_RDY_N=1 in IDLE.
//  FSM LOCKED:
//   - RX_DST_RDY_N[GRANT]=0 iff the output register can accept; all other RX_DST_RDY_N=1.
//   - On a transfer with RX_EOF_N[GRANT]=0: go to IDLE, RR_PTR <= (GRANT+1) mod INPUT_COUNT.
//  Latency: RX word to TX_SRC_RDY_N=0 is 1 cycle. Minimum gap between frames is 1 cycle (IDLE).
//  Single-word frame (SOF=EOF=SOP=EOP=0 on one word): legal; returns to IDLE after that word.
//  Ungranted inputs are never touched. Their DATA and framing are don't-care; they may wait indefinitely.
//  GRANT input drops SRC_RDY mid-frame: stay LOCKED, do not switch inputs.
//  RR_PTR wraps from INPUT_COUNT-1 to 0.
//  Reset mid-frame: the partial output word is dropped. The next grant restarts at input 0.
//  Input protocol (first word of a frame has SOF_N=0) is not checked; words pass verbatim.
// TESTING
//  1. Reset: after RESET_N rises, all RX_DST_RDY_N=1 and TX_SRC_RDY_N=1 until some input is ready.
//  2. Inputs 0..3 each offer one 3-part frame (parts 32B/64B/1B) in the same cycle, TX_DST_RDY_N=0:
//     frames appear in order 0,1,2,3; every frame is contiguous; framing bits and DREM are bit-exact.
//  3. Only input 2 active, 5 back-to-back 1-word frames: each frame is granted in turn;
//     TX_SRC_RDY_N=0 on every second cycle (1 IDLE cycle per frame).
//  4. Frame of 10 words on input 1, TX_DST_RDY_N toggling with 50% random pattern:
//     no word lost or duplicated; TX outputs stable while stalled.
//  5. Input 3 granted, then input 0 becomes ready mid-frame:
//     input 0 waits until input 3's EOF word; next grant goes to input 0 (wrap 3->0).
//  6. Random traffic, 2000 frames, random src/dst delays 0..10 cycles:
//     scoreboard per input; order is preserved within each input and no frames interleave.

Source files
------------

// File: rtl/fl_binder_rr.sv
// fl_binder_rr: merges INPUT_COUNT FrameLink streams into one stream using
// frame-atomic round-robin arbitration and a single registered output stage.
module fl_binder_rr #(
  parameter int DATA_WIDTH  = 64,
  parameter int DREM_WIDTH  = 3,
  parameter int INPUT_COUNT = 4
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic [INPUT_COUNT*DATA_WIDTH-1:0] RX_DATA,
  input  logic [INPUT_COUNT*DREM_WIDTH-1:0] RX_DREM,
  input  logic [INPUT_COUNT-1:0]            RX_SOF_N,
  input  logic [INPUT_COUNT-1:0]            RX_EOF_N,
  input  logic [INPUT_COUNT-1:0]            RX_SOP_N,
  input  logic [INPUT_COUNT-1:0]            RX_EOP_N,
  input  logic [INPUT_COUNT-1:0]            RX_SRC_RDY_N,
  output logic [INPUT_COUNT-1:0]            RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0]             TX_DATA,
  output logic [DREM_WIDTH-1:0]             TX_DREM,
  output logic                              TX_SOF_N,
  output logic                              TX_EOF_N,
  output logic                              TX_SOP_N,
  output logic                              TX_EOP_N,
  output logic                              TX_SRC_RDY_N,
  input  logic                              TX_DST_RDY_N
);

  localparam int GW = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DREM_WIDTH-1:0] drem_q, drem_d;
  logic [3:0]            frm_n_q, frm_n_d;   // {SOF, EOF, SOP, EOP}, active low

  logic                  scan_found;
  logic [GW-1:0]         scan_idx;
  logic [GW-1:0]         scan_cand;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DREM_WIDTH-1:0] sel_drem;
  logic [3:0]            sel_frm_n;
  logic                  sel_src_rdy_n;
  logic                  can_accept;
  logic                  rx_xfer;

  function automatic logic [GW-1:0] inc_mod(input logic [GW-1:0] idx);
    if (idx == GW'(INPUT_COUNT - 1)) begin
      return '0;
    end
    return idx + GW'(1);
  endfunction

  // Round-robin scan starting at the pointer; first ready input wins.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = rr_ptr_q;
    scan_cand  = rr_ptr_q;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      if (!scan_found && !RX_SRC_RDY_N[scan_cand]) begin
        scan_found = 1'b1;
        scan_idx   = scan_cand;
      end
      scan_cand = inc_mod(scan_cand);
    end
  end

  always_comb begin
    sel_data      = '0;
    sel_drem      = '0;
    sel_frm_n     = '1;
    sel_src_rdy_n = 1'b1;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      if (grant_q == GW'(i)) begin
        sel_data      = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_drem      = RX_DREM[i*DREM_WIDTH +: DREM_WIDTH];
        sel_frm_n     = {RX_SOF_N[i], RX_EOF_N[i], RX_SOP_N[i], RX_EOP_N[i]};
        sel_src_rdy_n = RX_SRC_RDY_N[i];
      end
    end
  end

  assign can_accept = !vld_q || !TX_DST_RDY_N;
  assign rx_xfer    = (state_q == S_LOCKED) && can_accept && !sel_src_rdy_n;

  always_comb begin
    for (int i = 0; i < INPUT_COUNT; i++) begin
      RX_DST_RDY_N[i] = !((state_q == S_LOCKED) && can_accept && (grant_q == GW'(i)));
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (scan_found) begin
          grant_d = scan_idx;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        // The grant is held across source stalls until the EOF word moves.
        if (rx_xfer && !sel_frm_n[2]) begin
          state_d  = S_IDLE;
          rr_ptr_d = inc_mod(grant_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_d   = vld_q;
    data_d  = data_q;
    drem_d  = drem_q;
    frm_n_d = frm_n_q;
    if (can_accept) begin
      vld_d = rx_xfer;
    end
    if (rx_xfer) begin
      data_d  = sel_data;
      drem_d  = sel_drem;
      frm_n_d = sel_frm_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      drem_q   <= '0;
      frm_n_q  <= '1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      drem_q   <= drem_d;
      frm_n_q  <= frm_n_d;
    end
  end

  assign TX_DATA      = data_q;
  assign TX_DREM      = drem_q;
  assign TX_SOF_N     = frm_n_q[3];
  assign TX_EOF_N     = frm_n_q[2];
  assign TX_SOP_N     = frm_n_q[1];
  assign TX_EOP_N     = frm_n_q[0];
  assign TX_SRC_RDY_N = !vld_q;

endmodule

// File: tb/tb_fl_binder_rr.sv
// tb_fl_binder_rr: directed and randomized FrameLink traffic into fl_binder_rr
// with per-input scoreboards, frame-atomicity and output-hold checks.
`timescale 1ns/1ps
module tb_fl_binder_rr;
  localparam int DW = 64;
  localparam int RW = 3;
  localparam int N  = 4;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic [N*DW-1:0] RX_DATA = '0;
  logic [N*RW-1:0] RX_DREM = '0;
  logic [N-1:0]    RX_SOF_N = '1, RX_EOF_N = '1, RX_SOP_N = '1, RX_EOP_N = '1;
  logic [N-1:0]    RX_SRC_RDY_N = '1;
  logic [N-1:0]    RX_DST_RDY_N;
  logic [DW-1:0]   TX_DATA;
  logic [RW-1:0]   TX_DREM;
  logic            TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N;
  logic            TX_SRC_RDY_N;
  logic            TX_DST_RDY_N = 1'b0;

  fl_binder_rr #(.DATA_WIDTH(DW), .DREM_WIDTH(RW), .INPUT_COUNT(N)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .RX_DATA(RX_DATA), .RX_DREM(RX_DREM),
    .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N), .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N),
    .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
    .TX_DATA(TX_DATA), .TX_DREM(TX_DREM),
    .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N), .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N),
    .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] drem;
    logic          sof_n, eof_n, sop_n, eop_n;
  } word_t;

  word_t    srcq [N][$];
  word_t    expq [N][$];
  int       gap [N];
  bit       en [N];
  int       seq [N];
  int       src_prob, src_max, dst_mode, dst_gap;
  logic [N-1:0] rx_xfer;
  bit       tx_xfer, in_frame, stalled_prev;
  word_t    prev_word;
  int       cur_src, cyc, tx_words;
  int       sof_order[$];
  int       n_chk, n_fail;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t tx_word();
    return {TX_DATA, TX_DREM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N};
  endfunction

  function automatic int remaining();
    int r = 0;
    for (int i = 0; i < N; i++) r += expq[i].size();
    return r;
  endfunction

  function automatic word_t mkword(input int i, input int widx, input int drem,
                                   input bit sof, input bit eof, input bit sop, input bit eop);
    word_t w;
    w.data  = {8'(i), 8'(seq[i]), 16'(widx), 32'($urandom)};
    w.drem  = RW'(drem);
    w.sof_n = !sof;
    w.eof_n = !eof;
    w.sop_n = !sop;
    w.eop_n = !eop;
    return w;
  endfunction

  task automatic add_word(input int i, input word_t w);
    srcq[i].push_back(w);
    expq[i].push_back(w);
  endtask

  // Frame made of up to three parts given in bytes (0 = part absent).
  task automatic add_parts(input int i, input int b0, input int b1, input int b2);
    int bytes[3];
    int np, nw, widx;
    bytes = '{b0, b1, b2};
    np = (b2 > 0) ? 3 : ((b1 > 0) ? 2 : 1);
    widx = 0;
    for (int p = 0; p < np; p++) begin
      nw = (bytes[p] + 7) / 8;
      for (int k = 0; k < nw; k++) begin
        add_word(i, mkword(i, widx, (k == nw - 1) ? (bytes[p] - 1) % 8 : 7,
                           (p == 0) && (k == 0), (p == np - 1) && (k == nw - 1),
                           k == 0, k == nw - 1));
        widx++;
      end
    end
    seq[i]++;
  endtask

  task automatic add_rand(input int i);
    int nw;
    nw = int'($urandom_range(3, 1));
    for (int k = 0; k < nw; k++) begin
      add_word(i, mkword(i, k, int'($urandom_range(7)), k == 0, k == nw - 1,
                         (k == 0) || ($urandom_range(1) == 1),
                         (k == nw - 1) || ($urandom_range(1) == 1)));
    end
    seq[i]++;
  endtask

  task automatic monitor(input word_t w);
    int s;
    word_t e;
    s = int'(w.data[DW-1:DW-8]);
    tx_words++;
    check("tx_src_tag_ok", s < N, 1'b1);
    if (s < N) begin
      check("tx_word_avail", expq[s].size() > 0, 1'b1);
      if (expq[s].size() > 0) begin
        e = expq[s].pop_front();
        check("tx_word", w, e);
      end
      if (in_frame) check("no_interleave", s, cur_src);
      else begin
        cur_src = s;
        sof_order.push_back(s);
      end
    end
    in_frame = w.eof_n;
  endtask

  task automatic step();
    word_t w;
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      if (rx_xfer[i]) begin
        void'(srcq[i].pop_front());
        gap[i] = ($urandom_range(99) < src_prob) ? int'($urandom_range(src_max)) : 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!en[i] || srcq[i].size() == 0) RX_SRC_RDY_N[i] = 1'b1;
      else if (gap[i] > 0) begin
        gap[i]--;
        RX_SRC_RDY_N[i] = 1'b1;
      end else begin
        w = srcq[i][0];
        RX_DATA[i*DW +: DW] = w.data;
        RX_DREM[i*RW +: RW] = w.drem;
        RX_SOF_N[i] = w.sof_n;
        RX_EOF_N[i] = w.eof_n;
        RX_SOP_N[i] = w.sop_n;
        RX_EOP_N[i] = w.eop_n;
        RX_SRC_RDY_N[i] = 1'b0;
      end
    end
    case (dst_mode)
      0: TX_DST_RDY_N = 1'b0;
      1: TX_DST_RDY_N = 1'($urandom_range(1));
      default: begin
        if (tx_xfer) dst_gap = ($urandom_range(99) < 30) ? int'($urandom_range(10)) : 0;
        if (dst_gap > 0) begin
          dst_gap--;
          TX_DST_RDY_N = 1'b1;
        end else TX_DST_RDY_N = 1'b0;
      end
    endcase
    #1;
    cyc++;
    for (int i = 0; i < N; i++) rx_xfer[i] = !RX_SRC_RDY_N[i] && !RX_DST_RDY_N[i];
    tx_xfer = !TX_SRC_RDY_N && !TX_DST_RDY_N;
    w = tx_word();
    if (stalled_prev) begin
      check("hold_vld", TX_SRC_RDY_N, 1'b0);
      check("hold_word", w, prev_word);
    end
    stalled_prev = !TX_SRC_RDY_N && TX_DST_RDY_N;
    prev_word = w;
    if (tx_xfer) monitor(w);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("rst_tx_srdy", TX_SRC_RDY_N, 1'b1);
    check("rst_rx_drdy", RX_DST_RDY_N, 4'hF);
    check("rst_tx_data", TX_DATA, 64'h0);
    check("rst_tx_frm", {TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_DREM}, 7'h78);
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      expq[i].delete();
      gap[i] = 0;
    end
    rx_xfer = '0;
    tx_xfer = 1'b0;
    in_frame = 1'b0;
    stalled_prev = 1'b0;
    dst_gap = 0;
    RX_SRC_RDY_N = '1;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic drain(input string tag, input int limit);
    int g = 0;
    while (remaining() > 0 && g < limit) begin
      step();
      g++;
    end
    check(tag, remaining(), 0);
  endtask

  initial begin
    int t0, first, last, w0;
    n_chk = 0; n_fail = 0; cyc = 0; tx_words = 0;
    src_prob = 0; src_max = 0; dst_mode = 0; dst_gap = 0;
    rx_xfer = '0; tx_xfer = 1'b0; in_frame = 1'b0; stalled_prev = 1'b0;
    prev_word = '0; cur_src = 0;
    for (int i = 0; i < N; i++) begin
      gap[i] = 0; en[i] = 1'b1; seq[i] = 0;
    end
    repeat (2) @(negedge CLK);
    do_reset();

    // 1: idle after reset
    for (int k = 0; k < 5; k++) begin
      step();
      check("t1_rx_drdy", RX_DST_RDY_N, 4'hF);
      check("t1_tx_srdy", TX_SRC_RDY_N, 1'b1);
    end

    // 2: four simultaneous 3-part frames, served 0,1,2,3
    sof_order.delete();
    for (int i = 0; i < N; i++) add_parts(i, 32, 64, 1);
    t0 = cyc + 1; first = -1; last = -1; w0 = tx_words;
    for (int g = 0; g < 200 && remaining() > 0; g++) begin
      step();
      if (tx_xfer) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    check("t2_drain", remaining(), 0);
    check("t2_latency", first - t0, 2);
    check("t2_span", last - first, 54);
    check("t2_words", tx_words - w0, 52);
    check("t2_nframes", sof_order.size(), 4);
    for (int k = 0; k < 4 && k < sof_order.size(); k++) check("t2_order", sof_order[k], k);
    repeat (3) step();

    // 3: five single-word frames on input 2
    for (int f = 0; f < 5; f++) add_parts(2, 1, 0, 0);
    for (int s = 1; s <= 12; s++) begin
      step();
      check("t3_srdy", TX_SRC_RDY_N, ((s >= 3) && (s % 2 == 1)) ? 1'b0 : 1'b1);
    end
    check("t3_drain", remaining(), 0);
    repeat (3) step();

    // 4: 10-word frame on input 1 with random consumer stalls
    dst_mode = 1;
    w0 = tx_words;
    add_parts(1, 80, 0, 0);
    drain("t4_drain", 300);
    check("t4_words", tx_words - w0, 10);
    dst_mode = 0;
    repeat (3) step();

    // 5: input 3 locked, input 0 arrives mid-frame and must wait
    sof_order.delete();
    add_parts(3, 48, 0, 0);
    repeat (3) step();
    add_parts(0, 16, 0, 0);
    en[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_wait0_stall", RX_DST_RDY_N[0], 1'b1);
    end
    en[3] = 1'b1;
    for (int g = 0; g < 50; g++) begin
      step();
      check("t5_wait0", RX_DST_RDY_N[0], 1'b1);
      if (rx_xfer[3] && !RX_EOF_N[3]) break;
    end
    drain("t5_drain", 50);
    check("t5_nframes", sof_order.size(), 2);
    if (sof_order.size() == 2) begin
      check("t5_first", sof_order[0], 3);
      check("t5_wrap", sof_order[1], 0);
    end
    repeat (3) step();

    // Reset mid-frame: next arbitration restarts at input 0
    add_parts(2, 64, 0, 0);
    repeat (5) step();
    do_reset();
    sof_order.delete();
    add_parts(1, 16, 0, 0);
    add_parts(2, 16, 0, 0);
    add_parts(0, 16, 0, 0);
    drain("trst_drain", 100);
    check("trst_nframes", sof_order.size(), 3);
    for (int k = 0; k < 3 && k < sof_order.size(); k++) check("trst_order", sof_order[k], k);
    repeat (3) step();

    // 6: random traffic, 2000 frames
    sof_order.delete();
    src_prob = 30; src_max = 10; dst_mode = 2;
    for (int f = 0; f < 2000; f++) add_rand(int'($urandom_range(N - 1)));
    drain("t6_drain", 60000);
    check("t6_nframes", sof_order.size(), 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
